// File: rtl/box_eat_ctrl.sv
// Food box consumer: requests candidates, validates range/grid/body overlap,
// then watches the snake head for an eat event and keeps the score.
module box_eat_ctrl #(
  parameter  int GRID    = 10,
  parameter  int X_MIN   = 0,
  parameter  int X_MAX   = 630,
  parameter  int Y_MIN   = 0,
  parameter  int Y_MAX   = 470,
  parameter  int MAX_LEN = 32,
  parameter  int SETTLE  = 2,
  localparam int AW      = $clog2(MAX_LEN),
  localparam int CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [9:0]    head_x,
  input  logic [9:0]    head_y,
  input  logic [5:0]    snake_len,
  output logic [AW-1:0] seg_addr,
  input  logic [9:0]    seg_x,
  input  logic [9:0]    seg_y,
  input  logic [9:0]    box_x,
  input  logic [9:0]    box_y,
  output logic          drive,
  output logic          box_ok,
  output logic          eat,
  output logic [7:0]    score,
  output logic [3:0]    retries
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_RANGE,
    S_SCAN,
    S_READY
  } state_t;

  state_t        state_q, state_d;
  logic          run_q;
  logic          eat_q, eat_d;
  logic [7:0]    score_q, score_d;
  logic [3:0]    retries_q, retries_d;
  logic [AW-1:0] seg_addr_q, seg_addr_d;
  logic [5:0]    len_q, len_d;
  logic [5:0]    k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;

  int   bx, by;
  logic bad_box;
  logic seg_hit;
  logic head_hit;
  logic [3:0] retries_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      run_q      <= 1'b0;
      eat_q      <= 1'b0;
      score_q    <= '0;
      retries_q  <= '0;
      seg_addr_q <= '0;
      len_q      <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      eat_q      <= eat_d;
      score_q    <= score_d;
      retries_q  <= retries_d;
      seg_addr_q <= seg_addr_d;
      len_q      <= len_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    bx = int'(box_x);
    by = int'(box_y);
    bad_box = (bx < X_MIN) || (bx > X_MAX) ||
              (by < Y_MIN) || (by > Y_MAX) ||
              ((bx % GRID) != 0) || ((by % GRID) != 0);
    seg_hit  = (seg_x == box_x) && (seg_y == box_y);
    head_hit = step && (head_x == box_x) && (head_y == box_y);
    retries_inc = (retries_q == 4'hF) ? retries_q
                                      : retries_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    eat_d      = 1'b0;
    score_d    = score_q;
    retries_d  = retries_q;
    seg_addr_d = seg_addr_q;
    len_d      = len_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    drive      = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // Hold off one cycle after reset and after an eat pulse.
        if (run_q && !eat_q) begin
          drive   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(SETTLE - 1)) state_d = S_RANGE;
        else cnt_d = cnt_q + 1'b1;
      end
      S_RANGE: begin
        if (bad_box) begin
          retries_d = retries_inc;
          state_d   = S_REQ;
        end else if (snake_len == 6'd0) begin
          state_d = S_READY;
        end else begin
          seg_addr_d = '0;
          len_d      = snake_len;
          k_d        = '0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        // Cycle k compares the segment addressed in cycle k-1.
        if (k_q != 6'd0 && seg_hit) begin
          retries_d = retries_inc;
          state_d   = S_REQ;
        end else if (k_q == len_q) begin
          state_d = S_READY;
        end else begin
          k_d = k_q + 6'd1;
          if ((k_q + 6'd1) < len_q) seg_addr_d = seg_addr_q + 1'b1;
        end
      end
      S_READY: begin
        if (head_hit) begin
          eat_d     = 1'b1;
          score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          retries_d = '0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign box_ok   = (state_q == S_READY);
  assign eat      = eat_q;
  assign score    = score_q;
  assign retries  = retries_q;
  assign seg_addr = seg_addr_q;

endmodule

// File: tb/tb_box_eat_ctrl.sv
// Directed scoreboard bench for box_eat_ctrl: box generator and body
// memory models, accept/eat monitors, timing and saturation checks.
module tb_box_eat_ctrl;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] r;
  } acc_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
  } cand_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [9:0] head_x = '0, head_y = '0;
  logic [5:0] snake_len = '0;
  logic [4:0] seg_addr;
  logic [9:0] seg_x, seg_y;
  logic [9:0] box_x = '0, box_y = '0;
  logic       drive, box_ok, eat;
  logic [7:0] score;
  logic [3:0] retries;

  int n_chk = 0;
  int n_fail = 0;

  cand_t cand_q[$];
  acc_t  acc_q[$];
  int    sc_q[$];

  logic [9:0] mx[32];
  logic [9:0] my[32];

  box_eat_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .head_x    (head_x),
    .head_y    (head_y),
    .snake_len (snake_len),
    .seg_addr  (seg_addr),
    .seg_x     (seg_x),
    .seg_y     (seg_y),
    .box_x     (box_x),
    .box_y     (box_y),
    .drive     (drive),
    .box_ok    (box_ok),
    .eat       (eat),
    .score     (score),
    .retries   (retries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    seg_x <= mx[seg_addr];
    seg_y <= my[seg_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  cand_t c_g;
  always @(negedge clk) begin
    if (drive === 1'b1 && cand_q.size() > 0) begin
      c_g = cand_q.pop_front();
      box_x = c_g.x;
      box_y = c_g.y;
    end
  end

  logic ok_p = 1'b0, eat_p = 1'b0, drv_p = 1'b0;
  acc_t a_m;
  int   s_m;
  always @(negedge clk) begin
    if (box_ok === 1'b1 && ok_p !== 1'b1) begin
      if (acc_q.size() == 0) chk("acc_unexp", box_ok, 0);
      else begin
        a_m = acc_q.pop_front();
        chk("acc_x", box_x, a_m.x);
        chk("acc_y", box_y, a_m.y);
        chk("acc_retries", retries, a_m.r);
      end
    end
    if (eat === 1'b1) begin
      if (sc_q.size() == 0) chk("eat_unexp", eat, 0);
      else begin
        s_m = sc_q.pop_front();
        chk("eat_score", score, s_m);
        chk("eat_okfall", box_ok, 0);
      end
    end
    if (eat_p) chk("drv_after_eat", drive, 1);
    if (drv_p) chk("drv_twice", drive, 0);
    ok_p  = box_ok;
    eat_p = eat;
    drv_p = drive;
  end

  task automatic do_step(input logic [9:0] x, input logic [9:0] y);
    head_x = x;
    head_y = y;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_drive(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (drive !== 1'b1 && n < 60);
  endtask

  task automatic wait_ok();
    int n = 0;
    while (box_ok !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ok_wait", box_ok, 1);
  endtask

  task automatic push_box(input logic [9:0] x, input logic [9:0] y);
    cand_t c;
    c.x = x;
    c.y = y;
    cand_q.push_back(c);
  endtask

  task automatic push_acc(input logic [9:0] x, input logic [9:0] y,
                          input logic [3:0] r);
    acc_t a;
    a.x = x;
    a.y = y;
    a.r = r;
    acc_q.push_back(a);
  endtask

  initial begin
    int n;
    logic [9:0] cx, cy, nx;
    for (int i = 0; i < 32; i++) begin
      mx[i] = 10'(i * 10);
      my[i] = 10'd0;
    end
    snake_len = 6'd3;
    push_box(10'd100, 10'd50);
    push_acc(10'd100, 10'd50, 4'd0);

    // Reset state and first legal box latency
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_drive", drive, 0);
    chk("rst_eat", eat, 0);
    chk("rst_ok", box_ok, 0);
    chk("rst_score", score, 0);
    chk("rst_retries", retries, 0);
    chk("rst_addr", seg_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_drive", drive, 1);
    repeat (7) @(negedge clk);
    chk("lat_early", box_ok, 0);
    @(negedge clk);
    chk("lat_ok", box_ok, 1);
    chk("lat_retries", retries, 0);

    // Off-grid reject
    push_box(10'd105, 10'd50);
    push_box(10'd110, 10'd50);
    push_acc(10'd110, 10'd50, 4'd1);
    sc_q.push_back(1);
    do_step(10'd100, 10'd50);
    chk("eat1", eat, 1);
    @(negedge clk);
    chk("drv1", drive, 1);
    wait_drive(n);
    chk("rej_gap", n, 4);
    wait_ok();
    chk("rej_retries", retries, 1);

    // Body overlap on segment 2
    mx[2] = 10'd200;
    my[2] = 10'd200;
    push_box(10'd200, 10'd200);
    push_box(10'd300, 10'd100);
    push_acc(10'd300, 10'd100, 4'd1);
    sc_q.push_back(2);
    do_step(10'd110, 10'd50);
    chk("eat2", eat, 1);
    @(negedge clk);
    chk("drv2", drive, 1);
    wait_drive(n);
    chk("scan_gap", n, 8);
    wait_ok();

    // Miss then hit
    do_step(10'd310, 10'd100);
    chk("miss_eat", eat, 0);
    repeat (3) @(negedge clk);
    chk("miss_ok", box_ok, 1);
    chk("miss_score", score, 2);
    push_box(10'd400, 10'd400);
    push_acc(10'd400, 10'd400, 4'd0);
    sc_q.push_back(3);
    do_step(10'd300, 10'd100);
    chk("eat3", eat, 1);
    chk("eat3_ok", box_ok, 0);
    chk("eat3_score", score, 3);
    @(negedge clk);
    chk("drv3", drive, 1);
    chk("eat3_pulse", eat, 0);

    // Step during SCAN is ignored
    repeat (4) @(negedge clk);
    do_step(10'd400, 10'd400);
    chk("scan_step_eat", eat, 0);
    wait_ok();
    chk("scan_step_score", score, 3);

    // Score saturation
    snake_len = 6'd0;
    cx = 10'd400;
    cy = 10'd400;
    for (int i = 0; i < 254; i++) begin
      nx = 10'((i % 60) * 10);
      push_box(nx, 10'd20);
      push_acc(nx, 10'd20, 4'd0);
      sc_q.push_back((4 + i > 255) ? 255 : 4 + i);
      do_step(cx, cy);
      chk("sat_eat", eat, 1);
      wait_ok();
      cx = nx;
      cy = 10'd20;
    end
    chk("sat_score", score, 255);

    // Reset during the second scan address
    snake_len = 6'd3;
    push_box(10'd500, 10'd300);
    sc_q.push_back(255);
    do_step(cx, cy);
    chk("eat_last", eat, 1);
    @(negedge clk);
    chk("drv_last", drive, 1);
    repeat (5) @(negedge clk);
    chk("scan_addr1", seg_addr, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_drive", drive, 0);
    chk("mrst_eat", eat, 0);
    chk("mrst_ok", box_ok, 0);
    chk("mrst_score", score, 0);
    chk("mrst_retries", retries, 0);
    chk("mrst_addr", seg_addr, 0);
    push_box(10'd500, 10'd300);
    push_acc(10'd500, 10'd300, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_drive_after", drive, 1);
    wait_ok();
    repeat (2) @(negedge clk);

    chk("acc_left", acc_q.size(), 0);
    chk("score_left", sc_q.size(), 0);
    chk("cand_left", cand_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
